// File: rtl/mem_responder.sv
// Purpose : drum-style word store; one request at a time, served when the drum sector matches the address.
// Latency : strobe to mem_reply is 2 .. 2^ADDR_W*SECTOR_CYCLES+1 cycles, set by rotational position.
// Backpressure: none; a strobe while busy (or both strobes at once) is dropped and flagged on mem_error.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   mem_read_pulse/mem_write_pulse  one-cycle request strobes
//   mem_addr, mem_wdata             sampled together with the accepted strobe
//   mem_rdata                       read data register, updated only by reads
//   mem_reply                       one-cycle completion strobe
//   mem_busy                        high while a request is in flight (SEEK or REPLY)
//   mem_error                       one-cycle strobe, cycle after a rejected request
//   drum_pos                        sector currently under the heads
module mem_responder #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 31,
  parameter int SECTOR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_read_pulse,
  input  logic              mem_write_pulse,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_reply,
  output logic              mem_busy,
  output logic              mem_error,
  output logic [ADDR_W-1:0] drum_pos
);

  localparam int DIV_W = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SECTOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    REPLY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  logic [DIV_W-1:0]  divider;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              error_nxt;
  logic              accept;
  logic              access;
  logic              one_strobe;
  logic              any_strobe;

  // Drum rotation runs free of the request FSM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      divider  <= '0;
      drum_pos <= '0;
    end else if (divider == DIV_LAST) begin
      divider  <= '0;
      drum_pos <= drum_pos + ADDR_W'(1);
    end else begin
      divider  <= divider + DIV_W'(1);
    end
  end

  assign one_strobe = mem_read_pulse ^ mem_write_pulse;
  assign any_strobe = mem_read_pulse | mem_write_pulse;

  // Only evaluated in SEEK, so the acceptance cycle (still IDLE) never matches.
  assign access = (state == SEEK) && (drum_pos == addr_q) && (divider == '0);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (one_strobe) begin
          accept    = 1'b1;
          state_nxt = SEEK;
        end else if (any_strobe) begin
          error_nxt = 1'b1;
        end
      end
      SEEK: begin
        error_nxt = any_strobe;
        if (access) state_nxt = REPLY;
      end
      REPLY: begin
        error_nxt = any_strobe;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_error <= 1'b0;
      mem_rdata <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      mem_error <= error_nxt;
      if (accept) begin
        op_wr  <= mem_write_pulse;
        addr_q <= mem_addr;
        if (mem_write_pulse) wdata_q <= mem_wdata;
      end
      if (access && !op_wr) mem_rdata <= mem[addr_q];
    end
  end

  // Storage has no reset; the resetn gate stops an aborted write landing.
  always_ff @(posedge clk) begin
    if (resetn && access && op_wr) mem[addr_q] <= wdata_q;
  end

  assign mem_reply = (state == REPLY);
  assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_read_pulse;
  logic        mem_write_pulse;
  logic [9:0]  mem_addr;
  logic [30:0] mem_wdata;
  logic [30:0] mem_rdata;
  logic        mem_reply;
  logic        mem_busy;
  logic        mem_error;
  logic [9:0]  drum_pos;

  mem_responder #(.ADDR_W(10), .DATA_W(31), .SECTOR_CYCLES(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_read_pulse  (mem_read_pulse),
    .mem_write_pulse (mem_write_pulse),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_reply       (mem_reply),
    .mem_busy        (mem_busy),
    .mem_error       (mem_error),
    .drum_pos        (drum_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [9:0]  addr;
    logic [30:0] data;
  } exp_t;

  exp_t        rq[$];            // expected replies
  int          eq[$];            // expected mem_error cycles
  logic [30:0] mem_model [int];
  logic [30:0] rdata_model;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          busy_from = 1;
  int          busy_to = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dp_model(input int c);
    return (c - rel_cyc) & 1023;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input int exp_cyc);
    checks++;
    errors++;
    $display("FAIL %s: got nothing, expected at cycle %0d (now %0d)", name, exp_cyc, cyc);
  endtask

  // Monitor: compares every cycle outside reset against the scoreboard.
  exp_t mon_e;
  bit   mon_exp;
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        fail_evt("reply_missing", rq[0].cyc);
        void'(rq.pop_front());
      end
      mon_exp = (rq.size() > 0) && (rq[0].cyc == cyc);
      chk("mem_reply", 64'(mem_reply), 64'(mon_exp));
      if (mon_exp) begin
        mon_e = rq.pop_front();
        if (mon_e.rd) rdata_model = mon_e.data;
        else          mem_model[int'(mon_e.addr)] = mon_e.data;
      end
      chk("mem_rdata", 64'(mem_rdata), 64'(rdata_model));

      if (eq.size() > 0 && eq[0] < cyc) begin
        fail_evt("error_missing", eq[0]);
        void'(eq.pop_front());
      end
      mon_exp = (eq.size() > 0) && (eq[0] == cyc);
      chk("mem_error", 64'(mem_error), 64'(mon_exp));
      if (mon_exp) void'(eq.pop_front());

      chk("mem_busy", 64'(mem_busy), 64'(cyc >= busy_from && cyc <= busy_to));
      chk("drum_pos", 64'(drum_pos), 64'(dp_model(cyc)));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; drives strobes for the current cycle.
  task automatic issue(input bit rd, input bit wr, input logic [9:0] a, input logic [30:0] d);
    int   t;
    int   delta;
    exp_t e;
    t = cyc;
    mem_read_pulse  = rd;
    mem_write_pulse = wr;
    mem_addr        = a;
    mem_wdata       = d;
    if (rd || wr) begin
      if (t > busy_to && (rd ^ wr)) begin
        // Search starts the cycle after the strobe at drum_pos+1.
        delta  = (int'(a) - dp_model(t) - 1) & 1023;
        e.cyc  = t + 2 + delta;
        e.rd   = rd;
        e.addr = a;
        e.data = rd ? mem_model[int'(a)] : d;
        rq.push_back(e);
        busy_from = t + 1;
        busy_to   = e.cyc;
      end else begin
        eq.push_back(t + 1);
      end
    end
    step(1);
    mem_read_pulse  = 1'b0;
    mem_write_pulse = 1'b0;
  endtask

  task automatic wait_idle();
    int lim;
    lim = 0;
    while (cyc <= busy_to && lim < 3000) begin
      step(1);
      lim++;
    end
    if (lim >= 3000) fail_evt("wait_idle_timeout", busy_to);
    step(1);
  endtask

  task automatic step_to_dp(input int target);
    step((target - dp_model(cyc)) & 1023);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    rq.delete();
    eq.delete();
    busy_from   = 1;
    busy_to     = 0;
    rdata_model = '0;
    step(n);
    resetn  = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    resetn          = 1'b0;
    mem_read_pulse  = 1'b0;
    mem_write_pulse = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    rdata_model     = '0;

    // Outputs while reset is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  64'(mem_busy),  64'(0));
    chk("rst_reply", 64'(mem_reply), 64'(0));
    chk("rst_error", 64'(mem_error), 64'(0));
    chk("rst_rdata", 64'(mem_rdata), 64'(0));
    chk("rst_pos",   64'(drum_pos),  64'(0));
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    rel_cyc = cyc;

    // Write addr 5 at drum_pos 0: busy t+1..t+6, reply at t+6.
    issue(0, 1, 10'd5, 31'h12345678);
    wait_idle();

    // Read back addr 5.
    step(10);
    issue(1, 0, 10'd5, 31'h0);
    wait_idle();

    // Wrap: read addr 3 from drum_pos 4 -> reply at t+1024.
    issue(0, 1, 10'd3, 31'h0ABCDEF);
    wait_idle();
    step_to_dp(4);
    issue(1, 0, 10'd3, 31'h0);
    wait_idle();

    // Both strobes in IDLE: error only, storage untouched.
    issue(1, 1, 10'd5, 31'h7FFFFFFF);
    step(2);
    issue(1, 0, 10'd5, 31'h0);
    wait_idle();

    // Read strobe during SEEK of a write.
    step_to_dp(100);
    issue(0, 1, 10'd7, 31'h055AA55A);
    step(2);
    issue(1, 0, 10'd7, 31'h0);
    wait_idle();
    issue(1, 0, 10'd7, 31'h0);
    wait_idle();

    // Strobe in the REPLY cycle itself.
    issue(0, 1, 10'd8, 31'h00001111);
    while (cyc < busy_to) step(1);
    issue(1, 0, 10'd8, 31'h0);
    wait_idle();
    issue(1, 0, 10'd8, 31'h0);
    wait_idle();

    // Minimum latency: target one sector ahead.
    step_to_dp(4);
    issue(1, 0, 10'd5, 31'h0);
    wait_idle();

    // Reset mid-SEEK of a write aborts it.
    issue(0, 1, 10'd9, 31'h02222222);
    wait_idle();
    step_to_dp(200);
    issue(0, 1, 10'd9, 31'h03333333);
    step(3);
    do_reset(1);
    step(2);
    issue(1, 0, 10'd9, 31'h0);
    wait_idle();
    issue(1, 0, 10'd5, 31'h0);
    wait_idle();
    issue(1, 0, 10'd3, 31'h0);
    wait_idle();

    step(3);
    chk("replies_left", 64'(rq.size()), 64'(0));
    chk("errors_left",  64'(eq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
